// File: rtl/axis_reg_cmd.sv
// Byte-stream register command decoder: 'W' addr data / 'R' addr frames, one response byte each.
// Define CMD_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module axis_reg_cmd #(
   parameter int unsigned ADDR_BITS      = 2,
   parameter logic [7:0]  RESET_VALUE    = 8'h00,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [7:0]                     idata,
   input  logic                           ivalid,
   output logic                           iready,
   output logic [7:0]                     odata,
   output logic                           ovalid,
   input  logic                           oready,
   output logic [8*(2**ADDR_BITS)-1:0]    regs
);

   localparam int unsigned NREG = 2**ADDR_BITS;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RADDR = 3'd1;
   localparam logic [2:0] S_WADDR = 3'd2;
   localparam logic [2:0] S_WDATA = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [7:0] OP_W   = 8'h57;
   localparam logic [7:0] OP_R   = 8'h52;
   localparam logic [7:0] R_OK   = 8'h4B;
   localparam logic [7:0] R_UNK  = 8'h3F;
   localparam logic [7:0] R_RANG = 8'h21;

   logic [2:0]           state;
   logic [2:0]           state_nx;
   logic [7:0]           odata_nx;
   logic [7:0]           waddr;
   logic [7:0]           bank [NREG];
   logic                 accept;
   logic                 done;
   logic                 wr_en;
   logic                 timeout;
   logic [ADDR_BITS-1:0] ridx;
   logic [ADDR_BITS-1:0] widx;

   function automatic logic in_range(input logic [7:0] a);
      return (a >> ADDR_BITS) == 8'd0;
   endfunction

   // Handshake readiness depends on state only, never on ivalid.
   assign iready = (state != S_RESP);
   assign ovalid = (state == S_RESP);
   assign accept = ivalid && iready;
   assign done   = ovalid && oready;
   assign ridx   = idata[ADDR_BITS-1:0];
   assign widx   = waddr[ADDR_BITS-1:0];

   always_comb begin
      state_nx = state;
      odata_nx = odata;
      wr_en    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  (idata == OP_W): state_nx = S_WADDR;
                  (idata == OP_R): state_nx = S_RADDR;
                  default: begin
                     state_nx = S_RESP;
                     odata_nx = R_UNK;
                  end
               endcase
            end
         end
         S_RADDR: begin
            if (accept) begin
               state_nx = S_RESP;
               odata_nx = in_range(idata) ? bank[ridx] : R_RANG;
            end else if (timeout) begin
               state_nx = S_IDLE;
            end
         end
         S_WADDR: begin
            if (accept) begin
               state_nx = S_WDATA;
            end else if (timeout) begin
               state_nx = S_IDLE;
            end
         end
         S_WDATA: begin
            if (accept) begin
               state_nx = S_RESP;
               wr_en    = in_range(waddr);
               odata_nx = in_range(waddr) ? R_OK : R_RANG;
            end else if (timeout) begin
               state_nx = S_IDLE;
            end
         end
         S_RESP: begin
            if (done) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         odata <= 8'h00;
         waddr <= 8'h00;
      end else begin
         state <= state_nx;
         odata <= odata_nx;
         if (state == S_WADDR && accept) waddr <= idata;
      end
   end

   // The write lands on the accepting edge, ahead of any later read frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NREG; k++) bank[k] <= RESET_VALUE;
      end else if (wr_en) begin
         bank[widx] <= idata;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_regs
      assign regs[8*g +: 8] = bank[g];
   end

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tcnt;
   logic          parse;

   assign parse   = (state == S_RADDR) || (state == S_WADDR) ||
                    (state == S_WDATA);
   assign timeout = parse && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
      end else if (accept || !parse || timeout) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TW'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_reg_cmd.sv
// Scoreboard bench for axis_reg_cmd: frame-level reference model, random and directed traffic.
// Timeout scenarios run only when CMD_TIMEOUT_EN is defined.
module tb_axis_reg_cmd;

   localparam int AB   = 2;
   localparam int NREG = 4;
   localparam int TO   = 16;

   logic        clock;
   logic        reset;
   logic [7:0]  idata;
   logic        ivalid;
   logic        iready;
   logic [7:0]  odata;
   logic        ovalid;
   logic        oready;
   logic [31:0] regs;

   int total = 0;
   int bad   = 0;
   bit rnd   = 0;

   logic [7:0] mreg [NREG];
   logic [7:0] fr [$];
   logic [7:0] exq [$];

   axis_reg_cmd #(
      .ADDR_BITS(AB),
      .RESET_VALUE(8'h00),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .idata(idata),
      .ivalid(ivalid),
      .iready(iready),
      .odata(odata),
      .ovalid(ovalid),
      .oready(oready),
      .regs(regs)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   function automatic logic [31:0] flat();
      return {mreg[3], mreg[2], mreg[1], mreg[0]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NREG; k++) mreg[k] = 8'h00;
      fr.delete();
      exq.delete();
   endtask

   // Frame-level reference: whole frames map to one response byte.
   task automatic model_accept(input logic [7:0] b);
      logic [7:0] a;
      fr.push_back(b);
      if (fr[0] != 8'h57 && fr[0] != 8'h52) begin
         exq.push_back(8'h3F);
         fr.delete();
      end else if (fr[0] == 8'h52 && fr.size() == 2) begin
         a = fr[1];
         if (a < NREG) exq.push_back(mreg[a[1:0]]);
         else exq.push_back(8'h21);
         fr.delete();
      end else if (fr[0] == 8'h57 && fr.size() == 3) begin
         a = fr[1];
         if (a < NREG) begin
            mreg[a[1:0]] = fr[2];
            exq.push_back(8'h4B);
         end else begin
            exq.push_back(8'h21);
         end
         fr.delete();
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      idata  = b;
      ivalid = 1'b1;
      while (!iready && n < 300) begin
         @(posedge clock); #1;
         if (rnd) oready = 1'($urandom_range(0, 1));
         n++;
      end
      if (n >= 300) begin
         chk("iready_wait", {31'd0, iready}, 32'd1);
      end else begin
         @(posedge clock); #1;
         model_accept(b);
         if (rnd) oready = 1'($urandom_range(0, 1));
         chk("regs", regs, flat());
      end
   endtask

   task automatic idle(input int n);
      ivalid = 1'b0;
      repeat (n) begin
         @(posedge clock); #1;
         if (rnd) oready = 1'($urandom_range(0, 1));
      end
`ifdef CMD_TIMEOUT_EN
      if (n >= TO && fr.size() > 0) fr.delete();
`endif
   endtask

   task automatic drain();
      int n = 0;
      oready = 1'b1;
      while (exq.size() > 0 && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      chk("drain", exq.size(), 0);
   endtask

   // Monitor: every output handshake must match the head of the queue.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && ovalid && oready) begin
            if (exq.size() == 0) begin
               chk("unexpected_resp", {24'd0, odata}, 32'hFFFF_FFFF);
            end else begin
               chk("resp", {24'd0, odata}, {24'd0, exq.pop_front()});
            end
         end
      end
   end

   initial begin
      logic [7:0] a;
      int op;
      reset  = 1'b1;
      ivalid = 1'b0;
      idata  = 8'h00;
      oready = 1'b0;
      model_reset();

      @(negedge clock);
      chk("rst_iready", {31'd0, iready}, 32'd1);
      chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
      chk("rst_odata", {24'd0, odata}, 32'd0);
      chk("rst_regs", regs, 32'd0);
      @(posedge clock); #1;
      reset  = 1'b0;
      oready = 1'b1;
      @(negedge clock);
      chk("post_rst_iready", {31'd0, iready}, 32'd1);

      send(8'h57); send(8'h01); send(8'hA5); idle(0);
      chk("wr_regs", regs, 32'h0000_A500);
      send(8'h52); send(8'h01); idle(2);
      drain();

      send(8'h33); idle(1);
      send(8'h57); send(8'h04); send(8'hFF); idle(1);
      chk("oor_regs", regs, 32'h0000_A500);
      send(8'h52); send(8'h80); idle(1);
      drain();

      oready = 1'b0;
      send(8'h52); send(8'h00); idle(0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("bp_ovalid", {31'd0, ovalid}, 32'd1);
         chk("bp_odata", {24'd0, odata}, {24'd0, mreg[0]});
         chk("bp_iready", {31'd0, iready}, 32'd0);
      end
      @(posedge clock); #1;
      oready = 1'b1;
      @(negedge clock);
      chk("bp_hs", {31'd0, ovalid & oready}, 32'd1);
      @(posedge clock); #1;
      chk("bp_iready_after", {31'd0, iready}, 32'd1);
      chk("bp_ovalid_after", {31'd0, ovalid}, 32'd0);

      send(8'h57); send(8'h02); send(8'h3C);
      send(8'h52); send(8'h02); idle(0);
      drain();
      chk("b2b_regs", regs, 32'h003C_A500);

      send(8'h57); send(8'h03); idle(0);
      @(posedge clock); #1;
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      chk("mid_rst_iready", {31'd0, iready}, 32'd1);
      chk("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
      chk("mid_rst_regs", regs, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("after_rst_iready", {31'd0, iready}, 32'd1);
      chk("after_rst_ovalid", {31'd0, ovalid}, 32'd0);
      send(8'h52); send(8'h03); idle(0);
      drain();

`ifdef CMD_TIMEOUT_EN
      send(8'h57); idle(20);
      send(8'h52); send(8'h00); idle(0);
      drain();
      send(8'h57); idle(10); send(8'h01); idle(10); send(8'h77); idle(0);
      drain();
      chk("to_regs", regs, 32'h0000_7700);
`endif

      rnd = 1;
      for (int i = 0; i < 150; i++) begin
         op = int'($urandom_range(0, 9));
         a = ($urandom_range(0, 4) == 4) ? 8'($urandom_range(4, 255))
                                         : 8'($urandom_range(0, 3));
         if (op < 4) begin
            send(8'h57); idle(int'($urandom_range(0, 2)));
            send(a); idle(int'($urandom_range(0, 2)));
            send(8'($urandom));
         end else if (op < 8) begin
            send(8'h52); idle(int'($urandom_range(0, 2)));
            send(a);
         end else if (op == 8) begin
            send(8'h30 + 8'($urandom_range(0, 15)));
         end else begin
            send(8'($urandom));
         end
         idle(int'($urandom_range(0, 2)));
      end
      rnd = 0;
      idle(0);
      fr.delete();
      drain();
      chk("final_regs", regs, flat());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
